tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter LANES, default 4: data words per frame; legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: bits per word.
REQ-003 SHALL have parameter SYNC_WORD, default 8'hA5: frame delimiter; width WIDTH.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: serial TDM word.
REQ-008 SHALL have port in_ready, output, 1: word accepted when in_valid & in_ready.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a complete frame.
REQ-010 SHALL have port out_data, output, LANES*WIDTH: lane k at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port out_ready, input, 1: frame consumed when out_valid & out_ready.
REQ-012 SHALL have port lock, output, 1: high when state is not HUNT.
REQ-013 SHALL have port err_count, output, 8: saturating framing/check error count.

Function
REQ-014 SHALL implement states HUNT, COLLECT, CHECK (macro only), HOLD and EXPECT.
REQ-015 In HUNT, an accepted word equal to SYNC_WORD SHALL go to COLLECT with lane counter 0; other words are discarded and not counted as errors.
REQ-016 In COLLECT, each accepted word SHALL be stored in lane[counter]; SYNC_WORD is ordinary data here.
REQ-017 On lane LANES-1 accepted, state SHALL go to HOLD (or CHECK when enabled); out_valid SHALL rise the next cycle (1-cycle latency).
REQ-018 In HOLD, in_ready SHALL be 0; out_valid and out_data SHALL be held stable until out_valid & out_ready.
REQ-019 On that handshake, the state SHALL go to EXPECT, out_valid SHALL drop and in_ready SHALL be 1 the next cycle.
REQ-020 In EXPECT, SYNC_WORD SHALL go to COLLECT; any other accepted word SHALL increment err_count and go to HUNT.
REQ-021 in_ready SHALL be 1 in all states except HOLD.
REQ-022 err_count SHALL saturate at 255 and never wrap.
REQ-023 Cycles with in_valid low SHALL leave state and lane counter unchanged.

Reset
REQ-024 While rst is high, the block SHALL enter HUNT and drive out_valid=0, out_data=0, lock=0, err_count=0 and in_ready=0; in_ready SHALL be 1 the cycle after rst falls.
REQ-025 rst mid-frame SHALL discard the partial frame with no err_count change.

Configuration
REQ-026 With TDM_DEMUX_CHECKSUM_EN defined:
- each frame SHALL carry one extra word after lane LANES-1, equal to the XOR of all lane words;
- it SHALL be accepted in CHECK;
- on match, go to HOLD;
- on mismatch, drop the frame (no out_valid), increment err_count, go to HUNT.
REQ-027 Without TDM_DEMUX_CHECKSUM_EN, there SHALL be no CHECK state, no checksum word and no checksum logic.

Structure
REQ-028 Package tdm_demux_pkg SHALL hold the state enum typedef, the default SYNC_WORD constant and the err_count width constant.
REQ-029 Sub-module tdm_checksum (running XOR accumulator, clear on sync) SHALL be instantiated only under TDM_DEMUX_CHECKSUM_EN.

Verification (LANES=4, WIDTH=8, SYNC_WORD=A5)
REQ-030 After reset, send A5,11,22,33,44 -> out_valid=1 the cycle after 44 is accepted; out_data=32'h44332211; lock=1; err_count=0.
REQ-031 Send 00,FF,5A then A5,01,02,03,04 -> lock=0 until A5 is accepted; out_data=32'h04030201; err_count=0.
REQ-032 Complete a frame, then send 5A in EXPECT -> err_count=1 and lock=0 the next cycle; A5 then relocks.
REQ-033 Frame complete, out_ready low for 3 cycles -> out_valid and out_data stable and in_ready=0; out_ready high -> out_valid=0 and in_ready=1 the next cycle.
REQ-034 With the macro, send A5,11,22,33,44,44 -> frame delivered; send A5,11,22,33,44,45 -> no out_valid, err_count +1, lock=0.
REQ-035 Assert rst after A5,11,22 -> the cycle after rst falls, all outputs are 0 except in_ready=1, state is HUNT and err_count=0.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM frame demultiplexer.
// The CHECK state exists only when TDM_DEMUX_CHECKSUM_EN is defined.
package tdm_demux_pkg;

  localparam int unsigned ERR_W = 8;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_COLLECT = 3'd1,
`ifdef TDM_DEMUX_CHECKSUM_EN
    ST_CHECK   = 3'd2,
`endif
    ST_HOLD    = 3'd3,
    ST_EXPECT  = 3'd4
  } state_e;

  // Saturating increment for the framing error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/tdm_checksum.sv
// Running XOR of the lane words of one frame; cleared when a sync word is accepted.
module tdm_checksum #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM word stream to parallel frame demultiplexer with sync-word framing.
// Define TDM_DEMUX_CHECKSUM_EN to require and verify a trailing XOR checksum word per frame.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int unsigned      LANES     = 4,
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEFAULT_SYNC_WORD)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic                   lock,
  output logic [ERR_W-1:0]       err_count
);

  localparam int unsigned CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   lock_q, lock_d;
  logic [ERR_W-1:0]       err_count_q, err_count_d;
  logic                   accept_c;
  logic                   handshake_c;

`ifdef TDM_DEMUX_CHECKSUM_EN
  logic             acc_clear_c;
  logic             acc_en_c;
  logic [WIDTH-1:0] acc_c;

  tdm_checksum #(
    .WIDTH(WIDTH)
  ) u_checksum (
    .clk  (clk),
    .rst  (rst),
    .clear(acc_clear_c),
    .en   (acc_en_c),
    .din  (in_data),
    .acc  (acc_c)
  );
`endif

  // Frame FSM; out_data_q doubles as lane storage while collecting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    err_count_d = err_count_q;
    accept_c    = in_valid & in_ready_q;
    handshake_c = out_valid_q & out_ready;
`ifdef TDM_DEMUX_CHECKSUM_EN
    acc_clear_c = 1'b0;
    acc_en_c    = 1'b0;
`endif

    case (state_q)
      ST_HUNT: begin
        if (accept_c && (in_data == SYNC_WORD)) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
`ifdef TDM_DEMUX_CHECKSUM_EN
          acc_clear_c = 1'b1;
`endif
        end
      end
      ST_COLLECT: begin
        if (accept_c) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              out_data_d[k*WIDTH +: WIDTH] = in_data;
            end
          end
`ifdef TDM_DEMUX_CHECKSUM_EN
          acc_en_c = 1'b1;
`endif
          if (cnt_q == LAST_LANE) begin
`ifdef TDM_DEMUX_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_HOLD;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef TDM_DEMUX_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_c) begin
          if (in_data == acc_c) begin
            state_d = ST_HOLD;
          end else begin
            state_d     = ST_HUNT;
            err_count_d = sat_inc(err_count_q);
          end
        end
      end
`endif
      ST_HOLD: begin
        if (handshake_c) begin
          state_d = ST_EXPECT;
        end
      end
      ST_EXPECT: begin
        if (accept_c) begin
          if (in_data == SYNC_WORD) begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
`ifdef TDM_DEMUX_CHECKSUM_EN
            acc_clear_c = 1'b1;
`endif
          end else begin
            state_d     = ST_HUNT;
            err_count_d = sat_inc(err_count_q);
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    out_valid_d = (state_d == ST_HOLD);
    in_ready_d  = (state_d != ST_HOLD);
    lock_d      = (state_d != ST_HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      lock_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      lock_q      <= lock_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign lock      = lock_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (LANES=4, WIDTH=8, SYNC_WORD=A5), directed steps plus random traffic.
// Follows TDM_DEMUX_CHECKSUM_EN the same way the RTL does.
module tb_tdm_demux;

  localparam int unsigned LANES = 4;
  localparam int unsigned WIDTH = 8;
  localparam logic [7:0]  SYNC  = 8'hA5;
`ifdef TDM_DEMUX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int unsigned NWORDS = CK ? LANES + 1 : LANES;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_ready;
  logic                   lock;
  logic [7:0]             err_count;

  int checks;
  int failures;

  // Behavioural reference: what a frame receiver should show after each clock.
  bit                     m_synced;
  bit                     m_expect;
  bit                     m_holding;
  logic [7:0]             m_frame[$];
  logic                   m_in_ready;
  logic                   m_out_valid;
  logic [LANES*WIDTH-1:0] m_out_data;
  logic [7:0]             m_err;

  tdm_demux #(
    .LANES    (LANES),
    .WIDTH    (WIDTH),
    .SYNC_WORD(SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .lock     (lock),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clock();
    logic [7:0] x;
    bit ok;
    if (rst) begin
      m_synced = 0; m_expect = 0; m_holding = 0; m_frame.delete();
      m_in_ready = 1'b0; m_out_valid = 1'b0; m_out_data = '0; m_err = 8'd0;
      return;
    end
    if (m_holding) begin
      if (out_ready) begin
        m_holding = 0; m_expect = 1; m_out_valid = 1'b0;
      end
    end else if (in_valid && m_in_ready) begin
      if (!m_synced || m_expect) begin
        if (in_data == SYNC) begin
          m_synced = 1; m_expect = 0; m_frame.delete();
        end else if (m_expect) begin
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
          m_synced = 0; m_expect = 0;
        end
      end else begin
        m_frame.push_back(in_data);
        if (m_frame.size() == NWORDS) begin
          x = 8'h00;
          for (int k = 0; k < LANES; k++) x = x ^ m_frame[k];
          ok = !CK || (m_frame[LANES] == x);
          if (ok) begin
            m_holding = 1; m_out_valid = 1'b1; m_out_data = '0;
            for (int k = 0; k < LANES; k++) m_out_data[k*WIDTH +: WIDTH] = m_frame[k];
          end else begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            m_synced = 0;
          end
          m_frame.delete();
        end
      end
    end
    m_in_ready = !m_holding;
  endtask

  task automatic compare_model();
    check("model_out_valid", 64'(out_valid), 64'(m_out_valid));
    check("model_in_ready", 64'(in_ready), 64'(m_in_ready));
    check("model_lock", 64'(lock), 64'(m_synced));
    check("model_err_count", 64'(err_count), 64'(m_err));
    if (m_out_valid) check("model_out_data", 64'(out_data), 64'(m_out_data));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    model_clock();
    #1;
    compare_model();
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  // Sync word, four lanes, and the checksum word when that feature is built in.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send(SYNC); send(a); send(b); send(c); send(d);
    if (CK) send(a ^ b ^ c ^ d);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
  endtask

  logic [LANES*WIDTH-1:0] held;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_lock", 64'(lock), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic frame delivery.
    send(SYNC);
    check("sync_lock", 64'(lock), 64'd1);
    send(8'h11); send(8'h22); send(8'h33);
    check("partial_no_valid", 64'(out_valid), 64'd0);
    send(8'h44);
    if (CK) send(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    check("frame1_valid", 64'(out_valid), 64'd1);
    check("frame1_data", 64'(out_data), 64'h44332211);
    check("frame1_lock", 64'(lock), 64'd1);
    check("frame1_err", 64'(err_count), 64'd0);
    step(1'b0, 8'h00, 1'b1);
    check("hs_valid_drop", 64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);

    // Junk before sync is discarded silently.
    pulse_reset();
    send(8'h00); check("hunt_lock_00", 64'(lock), 64'd0);
    send(8'hFF); check("hunt_lock_ff", 64'(lock), 64'd0);
    send(8'h5A); check("hunt_lock_5a", 64'(lock), 64'd0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    check("frame2_data", 64'(out_data), 64'h04030201);
    check("frame2_err", 64'(err_count), 64'd0);
    step(1'b0, 8'h00, 1'b1);

    // Wrong word where a sync is expected.
    send(8'h5A);
    check("expect_err", 64'(err_count), 64'd1);
    check("expect_unlock", 64'(lock), 64'd0);
    send(SYNC);
    check("relock", 64'(lock), 64'd1);

    // Back-pressure: output held while out_ready is low.
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    if (CK) send(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    held = out_data;
    check("bp_data_first", 64'(held), 64'hEFBEADDE);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h77, 1'b0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    step(1'b0, 8'h00, 1'b1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);

`ifdef TDM_DEMUX_CHECKSUM_EN
    // Checksum accepted, then checksum rejected.
    send(SYNC); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    check("ck_good_valid", 64'(out_valid), 64'd1);
    check("ck_good_data", 64'(out_data), 64'h44332211);
    step(1'b0, 8'h00, 1'b1);
    send(SYNC); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h45);
    check("ck_bad_valid", 64'(out_valid), 64'd0);
    check("ck_bad_err", 64'(err_count), 64'd2);
    check("ck_bad_lock", 64'(lock), 64'd0);
`endif

    // Reset in the middle of a frame.
    pulse_reset();
    send(SYNC); send(8'h11); send(8'h22);
    rst = 1'b1;
    step(1'b1, 8'h33, 1'b0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_lock", 64'(lock), 64'd0);
    check("midrst_err", 64'(err_count), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    send(8'h33);
    check("midrst_still_hunt", 64'(lock), 64'd0);

    // Error counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      send_frame(8'(i), 8'h5A, 8'hC3, 8'h0F);
      step(1'b0, 8'h00, 1'b1);
      send(8'h5A);
    end
    check("err_saturated", 64'(err_count), 64'd255);

    // Random traffic against the reference model.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom),
           ($urandom_range(0, 2) == 0));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
